// File: rtl/txfifo_frame_reader.sv
// Drains length-prefixed frames from the TX data FIFO and presents them to the
// MAC as a valid/ready word stream with SOP, EOP and byte enables.
//
// state | meaning
// IDLE  | no frame open; pops the next header as soon as the FIFO has data
// HDR   | header word is on q this cycle; decode the length
// DATA  | fetching payload words into the 2-entry output buffer
// DRAIN | discarding the payload of an oversize frame
module txfifo_frame_reader #(
    parameter int WIDTH   = 256,
    parameter int MAX_LEN = 9600
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             rdempty,
    input  logic [WIDTH-1:0] q,
    output logic             rdreq,
    input  logic             tx_ready,
    output logic             tx_valid,
    output logic [WIDTH-1:0] tx_data,
    output logic [31:0]      tx_be,
    output logic             tx_sop,
    output logic             tx_eop,
    output logic [31:0]      frame_cnt,
    output logic [15:0]      err_cnt,
    output logic             err_pulse,
    output logic             busy
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_HDR    = 2'd1;
    localparam logic [1:0]  ST_DATA   = 2'd2;
    localparam logic [1:0]  ST_DRAIN  = 2'd3;
    localparam logic [13:0] MAX_LEN_W = 14'(MAX_LEN);

    logic [1:0]       state_q, state_d;
    logic [9:0]       rem_q, rem_d;
    logic [31:0]      last_be_q, last_be_d;
    logic             first_q, first_d;
    logic             rd_vld_q, rd_vld_d;
    logic             rd_sop_q, rd_sop_d;
    logic             rd_eop_q, rd_eop_d;
    logic [31:0]      rd_be_q, rd_be_d;
    logic [WIDTH-1:0] buf_data_q [2];
    logic [WIDTH-1:0] buf_data_d [2];
    logic [31:0]      buf_be_q [2];
    logic [31:0]      buf_be_d [2];
    logic             buf_sop_q [2];
    logic             buf_sop_d [2];
    logic             buf_eop_q [2];
    logic             buf_eop_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [31:0]      frame_cnt_q, frame_cnt_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic             err_pulse_q, err_pulse_d;

    logic [13:0] hdr_len;
    logic [14:0] hdr_sum;
    logic [9:0]  hdr_words;
    logic [31:0] hdr_be;
    logic        buf_pop;
    logic        head_eop;
    logic [2:0]  fill;
    logic        room;
    logic        err_evt;

    assign hdr_len   = q[13:0];
    assign hdr_sum   = {1'b0, hdr_len} + 15'd31;
    assign hdr_words = hdr_sum[14:5];
    assign hdr_be    = (hdr_len[4:0] == 5'd0) ? 32'hFFFF_FFFF
                                              : ((32'd1 << hdr_len[4:0]) - 32'd1);

    assign tx_valid = (cnt_q != 2'd0);
    assign buf_pop  = tx_valid && tx_ready;
    assign head_eop = buf_eop_q[rd_ptr_q];

    // Count this cycle's pop so a steady stream sustains one word per cycle.
    assign fill = {1'b0, cnt_q} + {2'b00, rd_vld_q} - {2'b00, buf_pop};
    assign room = (fill < 3'd2);

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        last_be_d = last_be_q;
        first_d   = first_q;
        rd_vld_d  = 1'b0;
        rd_sop_d  = rd_sop_q;
        rd_eop_d  = rd_eop_q;
        rd_be_d   = rd_be_q;
        rdreq     = 1'b0;
        err_evt   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rdempty) begin
                    rdreq   = 1'b1;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (hdr_len == 14'd0) begin
                    err_evt = 1'b1;
                    state_d = ST_IDLE;
                end else if (hdr_len > MAX_LEN_W) begin
                    rem_d   = hdr_words;
                    state_d = ST_DRAIN;
                end else begin
                    rem_d     = hdr_words;
                    last_be_d = hdr_be;
                    first_d   = 1'b1;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!rdempty && room) begin
                    rdreq    = 1'b1;
                    rd_vld_d = 1'b1;
                    rd_sop_d = first_q;
                    rd_eop_d = (rem_q == 10'd1);
                    rd_be_d  = (rem_q == 10'd1) ? last_be_q : 32'hFFFF_FFFF;
                    first_d  = 1'b0;
                    rem_d    = rem_q - 10'd1;
                    if (rem_q == 10'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (!rdempty) begin
                    rdreq = 1'b1;
                    rem_d = rem_q - 10'd1;
                    if (rem_q == 10'd1) begin
                        err_evt = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Words land in the buffer the cycle after their rdreq, carrying the tags
    // computed when the read was issued.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            buf_data_d[i] = buf_data_q[i];
            buf_be_d[i]   = buf_be_q[i];
            buf_sop_d[i]  = buf_sop_q[i];
            buf_eop_d[i]  = buf_eop_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (rd_vld_q) begin
            buf_data_d[wr_ptr_q] = q;
            buf_be_d[wr_ptr_q]   = rd_be_q;
            buf_sop_d[wr_ptr_q]  = rd_sop_q;
            buf_eop_d[wr_ptr_q]  = rd_eop_q;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (buf_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, rd_vld_q} - {1'b0, buf_pop};
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q + {31'd0, buf_pop && head_eop};
        err_cnt_d   = err_cnt_q;
        if (err_evt && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
        err_pulse_d = err_evt;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            last_be_q   <= '0;
            first_q     <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_sop_q    <= 1'b0;
            rd_eop_q    <= 1'b0;
            rd_be_q     <= '0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_be_q[i]   <= '0;
                buf_sop_q[i]  <= 1'b0;
                buf_eop_q[i]  <= 1'b0;
            end
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            last_be_q   <= last_be_d;
            first_q     <= first_d;
            rd_vld_q    <= rd_vld_d;
            rd_sop_q    <= rd_sop_d;
            rd_eop_q    <= rd_eop_d;
            rd_be_q     <= rd_be_d;
            buf_data_q  <= buf_data_d;
            buf_be_q    <= buf_be_d;
            buf_sop_q   <= buf_sop_d;
            buf_eop_q   <= buf_eop_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign tx_data   = tx_valid ? buf_data_q[rd_ptr_q] : '0;
    assign tx_be     = tx_valid ? buf_be_q[rd_ptr_q] : '0;
    assign tx_sop    = tx_valid && buf_sop_q[rd_ptr_q];
    assign tx_eop    = tx_valid && head_eop;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign err_pulse = err_pulse_q;
    assign busy      = (state_q != ST_IDLE) || (cnt_q != 2'd0);

endmodule

// File: tb/tb_txfifo_frame_reader.sv
// Bench for txfifo_frame_reader: FIFO model with 1-cycle read latency, a
// frame-level expected-beat scoreboard, table vectors and corner sequences.
module tb_txfifo_frame_reader;
    localparam int WIDTH   = 256;
    localparam int MAX_LEN = 9600;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  be;
        logic         sop;
        logic         eop;
    } beat_t;

    typedef struct {
        int          len;
        int          exp_beats;
        int          exp_pops;
        logic [31:0] exp_last_be;
        int          exp_err;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_ = 1'b0;
    logic         rdempty;
    logic [255:0] q = '0;
    logic         rdreq;
    logic         tx_ready = 1'b1;
    logic         tx_valid;
    logic [255:0] tx_data;
    logic [31:0]  tx_be;
    logic         tx_sop;
    logic         tx_eop;
    logic [31:0]  frame_cnt;
    logic [15:0]  err_cnt;
    logic         err_pulse;
    logic         busy;

    int tests = 0;
    int fails = 0;

    logic [255:0] fifo[$];
    logic [255:0] push_q[$];
    logic [255:0] stage_q[$];
    beat_t        exp_q[$];
    int           fifo_n = 0;
    int           pops_total = 0;
    int           beats_total = 0;
    int           err_seen = 0;
    int           exp_frames = 0;
    int           exp_err = 0;
    int           rdy_mode = 0;
    logic         rdreq_s = 1'b0;
    logic [31:0]  last_be_seen = '0;
    logic         prev_stall = 1'b0;
    beat_t        prev_b;
    beat_t        mon_e;

    txfifo_frame_reader #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .reset_    (reset_),
        .rdempty   (rdempty),
        .q         (q),
        .rdreq     (rdreq),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_be     (tx_be),
        .tx_sop    (tx_sop),
        .tx_eop    (tx_eop),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt),
        .err_pulse (err_pulse),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign rdempty = (fifo_n == 0);

    // FIFO model: pops on the rdreq sampled in the previous half cycle.
    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            fifo.delete();
            fifo_n <= 0;
            q      <= '0;
        end else begin
            if (rdreq_s) begin
                if (fifo.size() == 0) begin
                    fails++;
                    $display("FAIL overpop: rdreq=1 with empty FIFO, required rdreq=0");
                end else begin
                    q <= fifo.pop_front();
                    pops_total++;
                end
            end
            while (push_q.size() > 0) fifo.push_back(push_q.pop_front());
            fifo_n <= fifo.size();
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ($urandom_range(0, 3) != 0);
            2:       tx_ready = ~tx_ready;
            default: tx_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        rdreq_s = rdreq;
        if (!reset_) begin
            prev_stall = 1'b0;
        end else begin
            if (rdreq && rdempty) begin
                fails++;
                $display("FAIL rdreq_while_empty: rdreq=1 rdempty=1, required rdreq=0");
            end
            if (err_pulse) err_seen++;
            if (prev_stall) begin
                tests++;
                if (!tx_valid || tx_data !== prev_b.data || tx_be !== prev_b.be ||
                    tx_sop !== prev_b.sop || tx_eop !== prev_b.eop) begin
                    fails++;
                    $display("FAIL stable: valid=%0b be=%h sop=%0b eop=%0b, required held be=%h sop=%0b eop=%0b",
                             tx_valid, tx_be, tx_sop, tx_eop, prev_b.be, prev_b.sop, prev_b.eop);
                end
            end
            if (tx_valid && tx_ready) begin
                beats_total++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL beat: unexpected beat be=%h sop=%0b eop=%0b, required none", tx_be, tx_sop, tx_eop);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (tx_data !== mon_e.data || tx_be !== mon_e.be ||
                        tx_sop !== mon_e.sop || tx_eop !== mon_e.eop) begin
                        fails++;
                        $display("FAIL beat: data=%h be=%h sop=%0b eop=%0b, required data=%h be=%h sop=%0b eop=%0b",
                                 tx_data[63:0], tx_be, tx_sop, tx_eop, mon_e.data[63:0], mon_e.be, mon_e.sop, mon_e.eop);
                    end
                end
                if (tx_eop) last_be_seen = tx_be;
            end
            prev_stall  = tx_valid && !tx_ready;
            prev_b.data = tx_data;
            prev_b.be   = tx_be;
            prev_b.sop  = tx_sop;
            prev_b.eop  = tx_eop;
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Reference: a frame of len bytes is a header plus ceil(len/32) words;
    // legal frames produce one beat per word, illegal ones only an error.
    task automatic add_frame(input int len);
        logic [255:0] w;
        beat_t        b;
        int           nw;
        int           tail;
        w        = rand256();
        w[13:0]  = len[13:0];
        stage_q.push_back(w);
        nw   = (len + 31) / 32;
        tail = len % 32;
        for (int i = 0; i < nw; i++) begin
            w = rand256();
            stage_q.push_back(w);
            if (len >= 1 && len <= MAX_LEN) begin
                b.data = w;
                b.sop  = (i == 0);
                b.eop  = (i == nw - 1);
                b.be   = (i == nw - 1 && tail != 0) ? ((32'd1 << tail) - 32'd1) : 32'hFFFF_FFFF;
                exp_q.push_back(b);
            end
        end
        if (len == 0 || len > MAX_LEN) exp_err++;
        else exp_frames++;
    endtask

    task automatic release_words(input int n);
        for (int i = 0; i < n; i++) begin
            if (stage_q.size() > 0) push_q.push_back(stage_q.pop_front());
        end
    endtask

    task automatic release_all();
        while (stage_q.size() > 0) push_q.push_back(stage_q.pop_front());
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || stage_q.size() != 0 || push_q.size() != 0 ||
                fifo.size() != 0 || busy) && k < 5000) begin
            tick(1);
            k++;
        end
        if (k >= 5000) begin
            tests++;
            fails++;
            $display("FAIL %s: idle not reached in 5000 cycles, %0d beats still expected", name, exp_q.size());
        end
        tick(4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        int   b0, p0, e0, k, lat, gap, len, r;

        vecs[0]  = '{64,   2,   3,   32'hFFFF_FFFF, 0};
        vecs[1]  = '{65,   3,   4,   32'h0000_0001, 0};
        vecs[2]  = '{32,   1,   2,   32'hFFFF_FFFF, 0};
        vecs[3]  = '{0,    0,   1,   32'h0000_0000, 1};
        vecs[4]  = '{40,   2,   3,   32'h0000_00FF, 0};
        vecs[5]  = '{9700, 0,   305, 32'h0000_0000, 1};
        vecs[6]  = '{1,    1,   2,   32'h0000_0001, 0};
        vecs[7]  = '{9600, 300, 301, 32'hFFFF_FFFF, 0};
        vecs[8]  = '{9601, 0,   302, 32'h0000_0000, 1};
        vecs[9]  = '{31,   1,   2,   32'h7FFF_FFFF, 0};
        vecs[10] = '{33,   2,   3,   32'h0000_0001, 0};

        reset_ = 1'b0;
        tick(3);
        check("rst rdreq", rdreq, 0);
        check("rst tx_valid", tx_valid, 0);
        check("rst tx_sop", tx_sop, 0);
        check("rst tx_eop", tx_eop, 0);
        check("rst err_pulse", err_pulse, 0);
        check("rst busy", busy, 0);
        check("rst tx_data", tx_data, 0);
        check("rst tx_be", tx_be, 0);
        check("rst frame_cnt", frame_cnt, 0);
        check("rst err_cnt", err_cnt, 0);
        reset_ = 1'b1;
        tick(2);

        // Header rdreq to first tx_valid.
        add_frame(64);
        release_all();
        k = 0;
        while (!rdreq && k < 50) begin @(negedge clk); k++; end
        check("hdr rdreq seen", (k < 50), 1);
        lat = 0;
        while (!tx_valid && lat < 50) begin @(negedge clk); lat++; end
        check("sop latency", lat, 4);
        check("first beat sop", tx_sop, 1);
        wait_idle("latency");
        check("latency frame_cnt", frame_cnt, exp_frames);

        for (int i = 0; i < 11; i++) begin
            b0 = beats_total;
            p0 = pops_total;
            e0 = err_seen;
            add_frame(vecs[i].len);
            release_all();
            wait_idle($sformatf("vec%0d", i));
            check($sformatf("vec%0d beats", i), beats_total - b0, vecs[i].exp_beats);
            check($sformatf("vec%0d pops", i), pops_total - p0, vecs[i].exp_pops);
            check($sformatf("vec%0d err_pulses", i), err_seen - e0, vecs[i].exp_err);
            if (vecs[i].exp_beats > 0)
                check($sformatf("vec%0d last_be", i), last_be_seen, vecs[i].exp_last_be);
            check($sformatf("vec%0d frame_cnt", i), frame_cnt, exp_frames);
            check($sformatf("vec%0d err_cnt", i), err_cnt, exp_err);
        end

        // Back-to-back frames: two idle cycles between EOP and next SOP.
        add_frame(65);
        add_frame(32);
        release_all();
        k = 0;
        while (!(tx_valid && tx_eop) && k < 100) begin @(negedge clk); k++; end
        check("b2b eop seen", (k < 100), 1);
        @(negedge clk);
        gap = 0;
        while (!tx_valid && gap < 50) begin gap++; @(negedge clk); end
        check("b2b bubble", gap, 2);
        check("b2b single sop", tx_sop, 1);
        check("b2b single eop", tx_eop, 1);
        check("b2b single be", tx_be, 32'hFFFF_FFFF);
        wait_idle("b2b");

        // Toggling ready with a long stall in the middle.
        rdy_mode = 2;
        add_frame(1024);
        release_all();
        tick(12);
        rdy_mode = 3;
        tick(2);
        p0 = pops_total;
        tick(18);
        check("stall pops bounded", ((pops_total - p0) <= 2), 1);
        check("stall valid held", tx_valid, 1);
        rdy_mode = 2;
        wait_idle("stall");
        rdy_mode = 0;
        check("stall frame_cnt", frame_cnt, exp_frames);

        // FIFO runs dry after 3 of 8 words.
        b0 = beats_total;
        add_frame(256);
        release_words(4);
        tick(20);
        check("starve tx_valid", tx_valid, 0);
        check("starve rdreq", rdreq, 0);
        check("starve busy", busy, 1);
        check("starve beats", beats_total - b0, 3);
        release_all();
        wait_idle("starve");
        check("starve total beats", beats_total - b0, 8);
        check("starve frame_cnt", frame_cnt, exp_frames);

        // Reset in the middle of a frame, with the FIFO cleared alongside.
        b0 = beats_total;
        add_frame(320);
        release_all();
        k = 0;
        while (beats_total == b0 && k < 100) begin tick(1); k++; end
        reset_ = 1'b0;
        #1;
        check("midrst tx_valid", tx_valid, 0);
        check("midrst rdreq", rdreq, 0);
        check("midrst tx_data", tx_data, 0);
        check("midrst tx_sop", tx_sop, 0);
        check("midrst busy", busy, 0);
        check("midrst frame_cnt", frame_cnt, 0);
        check("midrst err_cnt", err_cnt, 0);
        exp_q.delete();
        stage_q.delete();
        push_q.delete();
        exp_frames = 0;
        exp_err    = 0;
        err_seen   = 0;
        tick(2);
        reset_ = 1'b1;
        tick(1);
        add_frame(100);
        release_all();
        wait_idle("post reset");
        check("postrst frame_cnt", frame_cnt, 1);
        check("postrst err_cnt", err_cnt, 0);

        // Random lengths, random FIFO arrival and random ready.
        rdy_mode = 1;
        for (int f = 0; f < 40; f++) begin
            r = $urandom_range(0, 19);
            if (r == 0) len = 0;
            else if (r == 1) len = 9601 + $urandom_range(0, 60);
            else len = $urandom_range(1, 700);
            add_frame(len);
            while (stage_q.size() > 0) begin
                release_words($urandom_range(1, 6));
                tick($urandom_range(0, 3));
            end
        end
        wait_idle("random");
        rdy_mode = 0;
        check("random frame_cnt", frame_cnt, exp_frames);
        check("random err_cnt", err_cnt, exp_err);
        check("random err_pulses", err_seen, exp_err);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
